// File: rtl/burst_bus_if.sv
// burst_bus_if: SDRAM burst bus shared between the memory controller and one client.
//   clk           - bus clock (input to the interface)
//   cmd           - 1 = write burst, 0 = read burst
//   cmd_en        - command strobe, held until ready
//   addr          - burst address
//   wr_data       - write beat, one per cycle starting with the command cycle
//   data_mask     - per-byte write mask (1 = masked)
//   ready         - controller accepts the command this cycle
//   rd_data       - read beat
//   rd_data_valid - rd_data carries a beat this cycle
interface burst_bus_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 21
) (
    input logic clk
);
    logic                    cmd;
    logic                    cmd_en;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] data_mask;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_data_valid;

    modport master (
        input  clk, ready, rd_data, rd_data_valid,
        output cmd, cmd_en, addr, wr_data, data_mask
    );

    modport slave (
        input  clk, cmd, cmd_en, addr, wr_data, data_mask,
        output ready, rd_data, rd_data_valid
    );
endinterface

// File: rtl/burst_memory_tester.sv
// burst_memory_tester: burst-bus self-test master. Writes pattern-filled bursts over
// an address window, reads them back, compares every beat, counts errors and
// captures the first failure.
//   clk, reset          - clock and synchronous active-high reset
//   mem                 - burst bus master port
//   start               - one-cycle pulse, accepted in IDLE or DONE
//   mode                - 0 byte ramp, 1 LFSR, 2 walking one, 3 address tag
//   continuous          - repeat passes until reset
//   stop_on_error       - finish at the end of the burst where an error was seen
//   busy, done, error   - status
//   error_count         - saturating error count
//   pass_count          - completed passes (wraps)
//   first_err_*         - address, beat index, expected and actual data of the first error
// Optional feature: define BURST_MEMORY_TESTER_LFSR_EN to build the LFSR pattern
// generator; without it mode 1 produces the byte ramp of mode 0.
module burst_memory_tester #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 21,
    parameter int unsigned BURST_WORDS = 4,
    parameter int unsigned ADDR_COUNT  = 256,
    parameter int unsigned ADDR_STEP   = 1,
    parameter int unsigned GAP_CYCLES  = 22,
    parameter int unsigned RD_TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    burst_bus_if.master           mem,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic                  continuous,
    input  logic                  stop_on_error,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           error_count,
    output logic [15:0]           pass_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [7:0]            first_err_word,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_act
);
    localparam int unsigned          NB        = DATA_WIDTH / 8;
    localparam int unsigned          B_W       = ADDR_WIDTH + 1;
    localparam int unsigned          TMO_W     = $clog2(RD_TIMEOUT + 1);
    localparam logic [7:0]           LAST_BEAT = 8'(BURST_WORDS - 1);
    localparam logic [7:0]           GAP_LAST  = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(RD_TIMEOUT - 1);
    localparam logic [B_W-1:0]       B_LAST    = B_W'(ADDR_COUNT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_CMD, S_WR_BEATS, S_WR_GAP, S_RD_CMD,
        S_RD_WAIT, S_RD_GAP, S_NEXT, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic                  cont_q, cont_d;
    logic                  soe_q, soe_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [B_W-1:0]        b_q, b_d;
    logic [7:0]            beat_q, beat_d;
    logic [7:0]            gap_q, gap_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [15:0]           pass_q, pass_d;
    logic [15:0]           errc_q, errc_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH-1:0] fe_addr_q, fe_addr_d;
    logic [7:0]            fe_word_q, fe_word_d;
    logic [DATA_WIDTH-1:0] fe_exp_q, fe_exp_d;
    logic [DATA_WIDTH-1:0] fe_act_q, fe_act_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [7:0]            seed;
    logic [DATA_WIDTH-1:0] exp_beat;
    logic                  err_evt;
    logic [7:0]            err_word;
    logic [DATA_WIDTH-1:0] err_exp;
    logic [DATA_WIDTH-1:0] err_act;
    logic                  last_rx;
    state_t                after_wr, after_rd;

    assign seed     = 8'(b_q) + 8'(pass_q);
    assign after_wr = (GAP_CYCLES == 0) ? S_RD_CMD : S_WR_GAP;
    assign after_rd = (GAP_CYCLES == 0) ? S_NEXT : S_RD_GAP;

`ifdef BURST_MEMORY_TESTER_LFSR_EN
    localparam int unsigned  REP       = (DATA_WIDTH + 31) / 32;
    localparam logic [31:0]  LFSR_TAPS = 32'h80200003;
    localparam logic [31:0]  LFSR_INIT = 32'hACE10000;

    logic [31:0]       lfsr_q, lfsr_d;
    logic [REP*32-1:0] lfsr_rep;

    assign lfsr_rep = {REP{lfsr_q}};

    // Reseed on entry to a write command or a read data phase; step once per beat.
    always_comb begin : lfsr_next
        lfsr_d = lfsr_q;
        if ((state_d != state_q) && ((state_d == S_WR_CMD) || (state_d == S_RD_WAIT))) begin
            lfsr_d = LFSR_INIT ^ 32'(addr_d);
        end else if (beat_d == beat_q + 8'd1) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end
    end

    always_ff @(posedge clk) begin : lfsr_reg
        if (reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Expected beat for the current burst and beat index; shared by write and read.
    always_comb begin : exp_gen
        exp_beat = '0;
        case (mode_q)
`ifdef BURST_MEMORY_TESTER_LFSR_EN
            2'd1: exp_beat = lfsr_rep[REP*32-1 -: DATA_WIDTH];
`endif
            2'd2: exp_beat = DATA_WIDTH'(1) << ((32'(seed) + 32'(beat_q)) % DATA_WIDTH);
            2'd3: exp_beat = DATA_WIDTH'({addr_q, beat_q});
            default: begin
                for (int n = 0; n < NB; n++) begin
                    exp_beat[DATA_WIDTH-1-8*n -: 8] = 8'(32'(seed) + 32'(n) + NB * 32'(beat_q));
                end
            end
        endcase
    end

    assign mem.cmd_en    = (state_q == S_WR_CMD) || (state_q == S_RD_CMD);
    assign mem.cmd       = (state_q == S_WR_CMD);
    assign mem.addr      = addr_q;
    assign mem.wr_data   = ((state_q == S_WR_CMD) || (state_q == S_WR_BEATS)) ? exp_beat : '0;
    assign mem.data_mask = '0;

    // Next state, counters, error accounting and first-error capture.
    always_comb begin : fsm_next
        state_d   = state_q;
        mode_d    = mode_q;
        cont_d    = cont_q;
        soe_d     = soe_q;
        addr_d    = addr_q;
        b_d       = b_q;
        beat_d    = beat_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        pass_d    = pass_q;
        errc_d    = errc_q;
        error_d   = error_q;
        fe_addr_d = fe_addr_q;
        fe_word_d = fe_word_q;
        fe_exp_d  = fe_exp_q;
        fe_act_d  = fe_act_q;
        err_evt   = 1'b0;
        err_word  = beat_q;
        err_exp   = exp_beat;
        err_act   = mem.rd_data;
        last_rx   = mem.rd_data_valid && (beat_q == LAST_BEAT);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d    = mode;
                    cont_d    = continuous;
                    soe_d     = stop_on_error;
                    addr_d    = '0;
                    b_d       = '0;
                    beat_d    = '0;
                    pass_d    = '0;
                    errc_d    = '0;
                    error_d   = 1'b0;
                    fe_addr_d = '0;
                    fe_word_d = '0;
                    fe_exp_d  = '0;
                    fe_act_d  = '0;
                    state_d   = S_WR_CMD;
                end
            end
            S_WR_CMD: begin
                if (mem.ready) begin
                    beat_d = 8'd1;
                    gap_d  = '0;
                    state_d = (BURST_WORDS == 1) ? after_wr : S_WR_BEATS;
                end
            end
            S_WR_BEATS: begin
                beat_d = beat_q + 8'd1;
                if (beat_q == LAST_BEAT) begin
                    gap_d   = '0;
                    state_d = after_wr;
                end
            end
            S_WR_GAP: begin
                gap_d = gap_q + 8'd1;
                if (gap_q == GAP_LAST) begin
                    state_d = S_RD_CMD;
                end
            end
            S_RD_CMD: begin
                if (mem.ready) begin
                    tmo_d   = '0;
                    beat_d  = '0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                // A timeout overrides a simultaneous mismatch so only one error is counted.
                if ((tmo_q == TMO_LAST) && !last_rx) begin
                    err_evt  = 1'b1;
                    err_word = 8'hFF;
                    err_act  = mem.rd_data_valid ? mem.rd_data : '0;
                    gap_d    = '0;
                    state_d  = after_rd;
                end else if (mem.rd_data_valid) begin
                    err_evt = (mem.rd_data != exp_beat);
                    beat_d  = beat_q + 8'd1;
                    if (beat_q == LAST_BEAT) begin
                        gap_d   = '0;
                        state_d = after_rd;
                    end
                end
            end
            S_RD_GAP: begin
                gap_d = gap_q + 8'd1;
                if (gap_q == GAP_LAST) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                addr_d  = addr_q + ADDR_WIDTH'(ADDR_STEP);
                b_d     = b_q + B_W'(1);
                beat_d  = '0;
                state_d = S_WR_CMD;
                if (b_q == B_LAST) begin
                    pass_d = pass_q + 16'd1;
                    addr_d = '0;
                    b_d    = '0;
                    if (!cont_q) begin
                        state_d = S_DONE;
                    end
                end
                if (soe_q && error_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Read beats outside a read data phase are spurious; IDLE and a restart are exempt.
        if (mem.rd_data_valid && (state_q != S_RD_WAIT) && (state_q != S_IDLE) &&
            !((state_q == S_DONE) && start)) begin
            err_evt  = 1'b1;
            err_word = 8'hFE;
            err_exp  = '0;
            err_act  = mem.rd_data;
        end

        if (err_evt) begin
            error_d = 1'b1;
            if (errc_q != 16'hFFFF) begin
                errc_d = errc_q + 16'd1;
            end
            if (!error_q) begin
                fe_addr_d = addr_q;
                fe_word_d = err_word;
                fe_exp_d  = err_exp;
                fe_act_d  = err_act;
            end
        end

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin : regs
        if (reset) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            cont_q    <= 1'b0;
            soe_q     <= 1'b0;
            addr_q    <= '0;
            b_q       <= '0;
            beat_q    <= '0;
            gap_q     <= '0;
            tmo_q     <= '0;
            pass_q    <= '0;
            errc_q    <= '0;
            error_q   <= 1'b0;
            fe_addr_q <= '0;
            fe_word_q <= '0;
            fe_exp_q  <= '0;
            fe_act_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cont_q    <= cont_d;
            soe_q     <= soe_d;
            addr_q    <= addr_d;
            b_q       <= b_d;
            beat_q    <= beat_d;
            gap_q     <= gap_d;
            tmo_q     <= tmo_d;
            pass_q    <= pass_d;
            errc_q    <= errc_d;
            error_q   <= error_d;
            fe_addr_q <= fe_addr_d;
            fe_word_q <= fe_word_d;
            fe_exp_q  <= fe_exp_d;
            fe_act_q  <= fe_act_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign error_count    = errc_q;
    assign pass_count     = pass_q;
    assign first_err_addr = fe_addr_q;
    assign first_err_word = fe_word_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_act  = fe_act_q;
endmodule
